sd_sector_arbiter: RTL and testbench

Shares the single SD-card sector-read engine (the 512-byte block reader inside the SD memory top) between two requesters, e.g. the CPU boot loader and the asset/DMA loader. Round-robin arbitration picks one request at a time and issues it to the engine. The block streams that sector's 512 bytes back to the granted requester only, and reports completion, short transfers, engine errors and stalls.

---
 rtl/sd_sector_arbiter.sv | 160 ++++++++++++++++
 tb/tb_sd_sector_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/sd_sector_arbiter.sv
// Round-robin arbiter sharing one SD sector-read engine between two requesters.
// Grants in one cycle, forwards bytes one cycle late, and signals done, error, short/overrun or timeout.
module sd_sector_arbiter #(
  parameter int TIMEOUT_CYCLES = 2500000,
  parameter int SECTOR_BYTES   = 512
) (
  input  logic        clk_25mhz,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  input  logic [31:0] req_sector0,
  input  logic [31:0] req_sector1,
  output logic [1:0]  req_ready,
  output logic [7:0]  resp_data,
  output logic [1:0]  resp_valid,
  output logic        resp_last,
  output logic [1:0]  resp_done,
  output logic [1:0]  resp_err,
  output logic        sd_rd_start,
  output logic [31:0] sd_sector,
  output logic        sd_abort,
  input  logic [7:0]  sd_data,
  input  logic        sd_data_valid,
  input  logic        sd_done,
  input  logic        sd_error
);

  typedef enum logic [1:0] {IDLE, STREAM, FINISH} state_t;

  localparam logic [9:0]  LAST_IDX = 10'(SECTOR_BYTES - 1);
  // Counter is cleared to 0 in the event cycle, so the abort registered at this
  // value becomes visible exactly TIMEOUT_CYCLES cycles after that event.
  localparam logic [31:0] TO_LIMIT = 32'(TIMEOUT_CYCLES - 2);

  state_t      state, state_d;
  logic        gnt, gnt_d, ptr, ptr_d, done_pend, done_pend_d;
  logic [9:0]  cnt, cnt_d;
  logic [31:0] tcnt, tcnt_d;
  logic [1:0]  req_ready_d, resp_valid_d, resp_done_d, resp_err_d, gbit;
  logic [7:0]  resp_data_d;
  logic        resp_last_d, sd_rd_start_d, sd_abort_d;
  logic [31:0] sd_sector_d;
  logic        sel, fin_ok, fin_err;

  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      state       <= IDLE;
      gnt         <= 1'b0;
      ptr         <= 1'b0;
      done_pend   <= 1'b0;
      cnt         <= '0;
      tcnt        <= '0;
      req_ready   <= '0;
      resp_data   <= '0;
      resp_valid  <= '0;
      resp_last   <= 1'b0;
      resp_done   <= '0;
      resp_err    <= '0;
      sd_rd_start <= 1'b0;
      sd_sector   <= '0;
      sd_abort    <= 1'b0;
    end else begin
      state       <= state_d;
      gnt         <= gnt_d;
      ptr         <= ptr_d;
      done_pend   <= done_pend_d;
      cnt         <= cnt_d;
      tcnt        <= tcnt_d;
      req_ready   <= req_ready_d;
      resp_data   <= resp_data_d;
      resp_valid  <= resp_valid_d;
      resp_last   <= resp_last_d;
      resp_done   <= resp_done_d;
      resp_err    <= resp_err_d;
      sd_rd_start <= sd_rd_start_d;
      sd_sector   <= sd_sector_d;
      sd_abort    <= sd_abort_d;
    end
  end

  always_comb begin
    state_d       = state;
    gnt_d         = gnt;
    ptr_d         = ptr;
    done_pend_d   = done_pend;
    cnt_d         = cnt;
    tcnt_d        = tcnt;
    req_ready_d   = '0;
    resp_data_d   = resp_data;
    resp_valid_d  = '0;
    resp_last_d   = 1'b0;
    resp_done_d   = '0;
    resp_err_d    = '0;
    sd_rd_start_d = 1'b0;
    sd_sector_d   = sd_sector;
    sd_abort_d    = 1'b0;
    sel           = 1'b0;
    fin_ok        = 1'b0;
    fin_err       = 1'b0;
    gbit          = gnt ? 2'b10 : 2'b01;

    case (state)
      IDLE: begin
        if (|req_valid) begin
          sel           = (req_valid == 2'b11) ? ptr : req_valid[1];
          gnt_d         = sel;
          req_ready_d   = sel ? 2'b10 : 2'b01;
          sd_rd_start_d = 1'b1;
          sd_sector_d   = sel ? req_sector1 : req_sector0;
          cnt_d         = '0;
          tcnt_d        = '0;
          done_pend_d   = 1'b0;
          state_d       = STREAM;
        end
      end
      STREAM: begin
        tcnt_d = (sd_rd_start || sd_data_valid || sd_done) ? 32'd0 : tcnt + 32'd1;
        if (sd_error) begin
          fin_err = 1'b1;
        end else if (sd_done && !(sd_data_valid && cnt == LAST_IDX)) begin
          fin_err = 1'b1;
        end else if (sd_data_valid) begin
          resp_data_d  = sd_data;
          resp_valid_d = gbit;
          resp_last_d  = (cnt == LAST_IDX);
          cnt_d        = cnt + 10'd1;
          if (cnt == LAST_IDX) begin
            // A done arriving with the last byte is reported one cycle after it.
            done_pend_d = sd_done;
            state_d     = FINISH;
          end
        end else if (!sd_rd_start && tcnt == TO_LIMIT) begin
          sd_abort_d = 1'b1;
          fin_err    = 1'b1;
        end
      end
      FINISH: begin
        tcnt_d = (sd_data_valid || sd_done) ? 32'd0 : tcnt + 32'd1;
        if (done_pend) begin
          fin_ok = 1'b1;
        end else if (sd_error || sd_data_valid) begin
          fin_err = 1'b1;
        end else if (sd_done) begin
          fin_ok = 1'b1;
        end else if (tcnt == TO_LIMIT) begin
          sd_abort_d = 1'b1;
          fin_err    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (fin_ok) resp_done_d = gbit;
    if (fin_err) resp_err_d = gbit;
    if (fin_ok || fin_err) begin
      state_d = IDLE;
      ptr_d   = ~gnt;
    end
  end

endmodule

// File: tb/tb_sd_sector_arbiter.sv
// Scoreboard bench for sd_sector_arbiter: directed transfers push timed expected events, a monitor pops them.
module tb_sd_sector_arbiter;
  localparam int TMO = 50;
  localparam int SB  = 512;

  typedef struct packed {
    logic [1:0]  rdy;
    logic        start;
    logic [31:0] sector;
    logic [1:0]  vld;
    logic [7:0]  data;
    logic        last;
    logic [1:0]  done;
    logic [1:0]  err;
    logic        abort;
  } ev_t;

  logic        clk_25mhz = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [31:0] req_sector0, req_sector1;
  logic [1:0]  req_ready, resp_valid, resp_done, resp_err;
  logic [7:0]  resp_data, sd_data;
  logic        resp_last, sd_rd_start, sd_abort;
  logic [31:0] sd_sector;
  logic        sd_data_valid, sd_done, sd_error;

  int   cyc = 0;
  int   nvec = 0;
  int   nerr = 0;
  ev_t  exp_ev[$];
  int   exp_cyc[$];

  sd_sector_arbiter #(.TIMEOUT_CYCLES(TMO), .SECTOR_BYTES(SB)) dut (
    .clk_25mhz(clk_25mhz), .reset(reset),
    .req_valid(req_valid), .req_sector0(req_sector0), .req_sector1(req_sector1),
    .req_ready(req_ready), .resp_data(resp_data), .resp_valid(resp_valid),
    .resp_last(resp_last), .resp_done(resp_done), .resp_err(resp_err),
    .sd_rd_start(sd_rd_start), .sd_sector(sd_sector), .sd_abort(sd_abort),
    .sd_data(sd_data), .sd_data_valid(sd_data_valid), .sd_done(sd_done), .sd_error(sd_error)
  );

  always #20 clk_25mhz = ~clk_25mhz;
  always @(posedge clk_25mhz) cyc <= cyc + 1;

  function automatic logic [1:0] gb(input int g);
    return (g == 1) ? 2'b10 : 2'b01;
  endfunction

  function automatic ev_t ev_grant(input int g, input logic [31:0] s);
    ev_t e = '0;
    e.rdy = gb(g); e.start = 1'b1; e.sector = s;
    return e;
  endfunction

  function automatic ev_t ev_byte(input int g, input logic [7:0] d, input logic l);
    ev_t e = '0;
    e.vld = gb(g); e.data = d; e.last = l;
    return e;
  endfunction

  function automatic ev_t ev_end(input int g, input logic ok, input logic ab);
    ev_t e = '0;
    if (ok) e.done = gb(g); else e.err = gb(g);
    e.abort = ab;
    return e;
  endfunction

  task automatic push(input int c, input ev_t e);
    exp_cyc.push_back(c);
    exp_ev.push_back(e);
  endtask

  task automatic monitor_step();
    ev_t o, e;
    int  c;
    if (|{req_ready, sd_rd_start, resp_valid, resp_last, resp_done, resp_err, sd_abort}) begin
      o = '0;
      o.rdy = req_ready; o.start = sd_rd_start; o.sector = sd_rd_start ? sd_sector : 32'd0;
      o.vld = resp_valid; o.data = (|resp_valid) ? resp_data : 8'd0; o.last = resp_last;
      o.done = resp_done; o.err = resp_err; o.abort = sd_abort;
      nvec++;
      if (exp_ev.size() == 0) begin
        nerr++;
        $display("FAIL unexpected_event cyc=%0d got=%h required=none", cyc, o);
      end else begin
        e = exp_ev.pop_front();
        c = exp_cyc.pop_front();
        if (o !== e || cyc != c) begin
          nerr++;
          $display("FAIL event cyc=%0d got=%h required=%h at cyc %0d", cyc, o, e, c);
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk_25mhz);
    #1;
    sd_data_valid = 1'b0;
    sd_done       = 1'b0;
    sd_error      = 1'b0;
  endtask

  task automatic check_zero(input string name);
    logic [86:0] v;
    v = {req_ready, resp_data, resp_valid, resp_last, resp_done, resp_err, sd_rd_start, sd_sector, sd_abort};
    nvec++;
    if (v !== '0) begin
      nerr++;
      $display("FAIL %s got=%h required=0", name, v);
    end
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 200 && exp_ev.size() != 0; k++) tick();
    tick();
    nvec++;
    if (exp_ev.size() != 0) begin
      nerr++;
      $display("FAIL %s got=%0d pending events required=0", name, exp_ev.size());
      exp_ev.delete();
      exp_cyc.delete();
    end
  endtask

  // mode: 0 done after data, 1 done with last byte, 2 error, 3 short done, 4 overrun,
  //       5 timeout, 6 error on the same cycle as a byte, 7 done+error together, 8 reset mid-stream
  task automatic xfer(input logic [1:0] rv, input logic [31:0] s0, input logic [31:0] s1,
                      input int g, input int nbytes, input int mode, input int seed, input string name);
    int last_clr;
    tick();
    req_valid = rv; req_sector0 = s0; req_sector1 = s1;
    push(cyc + 1, ev_grant(g, (g == 1) ? s1 : s0));
    tick();
    req_valid = 2'b00;
    last_clr  = cyc;
    for (int i = 0; i < nbytes; i++) begin
      if (i % 128 == 64) repeat (3) tick();
      tick();
      sd_data_valid = 1'b1;
      sd_data       = 8'(i + seed);
      last_clr      = cyc;
      if (mode == 6 && i == nbytes - 1) begin
        sd_error = 1'b1;
        push(cyc + 1, ev_end(g, 1'b0, 1'b0));
      end else begin
        push(cyc + 1, ev_byte(g, 8'(i + seed), i == SB - 1));
        if (mode == 1 && i == SB - 1) begin
          sd_done = 1'b1;
          push(cyc + 2, ev_end(g, 1'b1, 1'b0));
        end
      end
    end
    case (mode)
      0: begin tick(); sd_done = 1'b1; push(cyc + 1, ev_end(g, 1'b1, 1'b0)); end
      2: begin tick(); sd_error = 1'b1; push(cyc + 1, ev_end(g, 1'b0, 1'b0)); end
      3: begin tick(); sd_done = 1'b1; push(cyc + 1, ev_end(g, 1'b0, 1'b0)); end
      4: begin tick(); sd_data_valid = 1'b1; sd_data = 8'hEE; push(cyc + 1, ev_end(g, 1'b0, 1'b0)); end
      5: push(last_clr + TMO, ev_end(g, 1'b0, 1'b1));
      7: begin tick(); sd_done = 1'b1; sd_error = 1'b1; push(cyc + 1, ev_end(g, 1'b0, 1'b0)); end
      8: begin
        tick();
        reset = 1'b1;
        tick();
        check_zero({name, "_outputs"});
        reset = 1'b0;
      end
      default: ;
    endcase
    tick();
    drain(name);
  endtask

  initial begin
    reset = 1'b1; req_valid = 2'b00; req_sector0 = '0; req_sector1 = '0;
    sd_data = '0; sd_data_valid = 1'b0; sd_done = 1'b0; sd_error = 1'b0;
    fork
      forever begin @(negedge clk_25mhz); monitor_step(); end
      begin
        #3000000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
      end
    join_none
    repeat (3) tick();
    check_zero("reset_state");
    reset = 1'b0;
    tick();
    check_zero("idle_after_reset");

    xfer(2'b11, 32'h0000_0010, 32'hABCD_0001, 0, SB,  0, 0,  "contend_first_r0");
    xfer(2'b11, 32'h0000_0020, 32'hABCD_0002, 1, SB,  1, 7,  "contend_r1_done_with_last");
    xfer(2'b11, 32'h0000_0030, 32'hABCD_0003, 0, 100, 2, 3,  "engine_error");
    xfer(2'b11, 32'h0000_0040, 32'hABCD_0004, 1, 300, 3, 9,  "short_transfer");
    xfer(2'b10, 32'h0000_0050, 32'hABCD_0005, 1, SB,  4, 1,  "overrun");
    xfer(2'b01, 32'h0000_0010, 32'h0000_0000, 0, SB,  0, 0,  "single_r0");
    xfer(2'b11, 32'h0000_0060, 32'h1234_5678, 1, 0,   5, 0,  "timeout_no_bytes");
    xfer(2'b11, 32'h0000_0070, 32'h1234_5679, 0, 10,  5, 5,  "timeout_mid_stream");
    xfer(2'b11, 32'h0000_0080, 32'h1234_567A, 1, SB,  5, 2,  "timeout_finish");
    xfer(2'b11, 32'hFFFF_FFFF, 32'h1234_567B, 0, 50,  6, 4,  "error_with_byte");
    xfer(2'b11, 32'h0000_0090, 32'h8000_0000, 1, SB,  7, 6,  "done_and_error");
    xfer(2'b01, 32'h0000_00A0, 32'h0000_0000, 0, SB,  0, 8,  "single_sets_ptr1");
    xfer(2'b01, 32'h0000_00B0, 32'h0000_0000, 0, 200, 8, 0,  "reset_mid_stream");
    xfer(2'b11, 32'h0000_00C0, 32'h5555_AAAA, 0, SB,  0, 11, "after_reset_r0");

    repeat (5) tick();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
